// File: rtl/spi_protocol_monitor.sv
// spi_protocol_monitor
//   Passive SPI slave-side protocol monitor. Taps SS_n/MOSI/MISO, samples
//   everything on the rising edge of clk, decodes each frame and reports
//   results and protocol errors. All outputs come straight from flops.
//
//   Frame: 1 start cycle, 3-bit command (MSB first), DATA_WIDTH-bit MOSI
//   payload, and for rd-data a DATA_WIDTH-bit MISO response; then SS_n
//   must rise within TAIL_MAX low cycles.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     SS_n, MOSI, MISO  tapped SPI pins
//     err_clr           clears err_status (a same-cycle pulse wins)
//     frame_done        1-cycle pulse per legally completed frame
//     frame_cmd         cmd[1:0] of last completed frame
//     frame_payload     MOSI payload of last completed frame
//     frame_resp        MISO response of last completed rd-data frame
//     err_pulse         1-cycle error pulses
//     err_status        sticky errors: [0] illegal cmd, [1] short frame,
//                       [2] long frame, [3] MISO violation, [4] order
//     cnt_*             legal completed frames per command
//
//   Optional: define SPI_MON_CNT_EN to build the four saturating frame
//   counters; otherwise the count ports are tied to 0.

module spi_protocol_monitor #(
    parameter int DATA_WIDTH = 8,
    parameter int TAIL_MAX   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SS_n,
    input  logic                  MOSI,
    input  logic                  MISO,
    input  logic                  err_clr,
    output logic                  frame_done,
    output logic [1:0]            frame_cmd,
    output logic [DATA_WIDTH-1:0] frame_payload,
    output logic [DATA_WIDTH-1:0] frame_resp,
    output logic [4:0]            err_pulse,
    output logic [4:0]            err_status,
    output logic [CNT_WIDTH-1:0]  cnt_wr_addr,
    output logic [CNT_WIDTH-1:0]  cnt_wr_data,
    output logic [CNT_WIDTH-1:0]  cnt_rd_addr,
    output logic [CNT_WIDTH-1:0]  cnt_rd_data
);

    // bit counter must reach both 2 (command) and DATA_WIDTH-1
    localparam int CW = $clog2(DATA_WIDTH) + 2;
    // tail counter must reach TAIL_MAX+1 so the long-frame flag fires once
    localparam int TW = $clog2(TAIL_MAX + 2);

    localparam int E_ILL   = 0;
    localparam int E_SHORT = 1;
    localparam int E_LONG  = 2;
    localparam int E_MISO  = 3;
    localparam int E_ORDER = 4;

    typedef enum logic [2:0] {
        IDLE, START, CMD, PAYLOAD, RESP, DONE, WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         tail_cnt_q, tail_cnt_d;
    logic [1:0]            cmd_sr_q, cmd_sr_d;
    logic [1:0]            cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] pay_sr_q, pay_sr_d;
    logic [DATA_WIDTH-1:0] resp_sr_q, resp_sr_d;
    logic                  after_resp_q, after_resp_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  miso_prev_q, miso_prev_d;

    logic                  frame_done_q, frame_done_d;
    logic [1:0]            frame_cmd_q, frame_cmd_d;
    logic [DATA_WIDTH-1:0] frame_payload_q, frame_payload_d;
    logic [DATA_WIDTH-1:0] frame_resp_q, frame_resp_d;
    logic [4:0]            err_pulse_q, err_pulse_d;
    logic [4:0]            err_status_q, err_status_d;

    logic [2:0]            cmd_full;

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        tail_cnt_d      = tail_cnt_q;
        cmd_sr_d        = cmd_sr_q;
        cmd_d           = cmd_q;
        pay_sr_d        = pay_sr_q;
        resp_sr_d       = resp_sr_q;
        after_resp_d    = 1'b0;
        rd_valid_d      = rd_valid_q;
        miso_prev_d     = MISO;
        frame_done_d    = 1'b0;
        frame_cmd_d     = frame_cmd_q;
        frame_payload_d = frame_payload_q;
        frame_resp_d    = frame_resp_q;
        err_pulse_d     = '0;

        cmd_full = {cmd_sr_q, MOSI};

        // MISO must hold while selected, except while the slave drives the
        // response and the one cycle it takes to release the line after it.
        if (!SS_n && (MISO != miso_prev_q) && (state_q != RESP) &&
            !((state_q == DONE) && after_resp_q))
            err_pulse_d[E_MISO] = 1'b1;
        if ((state_q == IDLE) && SS_n && MISO)
            err_pulse_d[E_MISO] = 1'b1;

        case (state_q)
            IDLE: begin
                if (!SS_n) state_d = START;
            end
            START: begin
                if (SS_n) begin
                    err_pulse_d[E_SHORT] = 1'b1;
                    state_d              = IDLE;
                end else begin
                    bit_cnt_d = '0;
                    state_d   = CMD;
                end
            end
            CMD: begin
                if (SS_n) begin
                    err_pulse_d[E_SHORT] = 1'b1;
                    state_d              = IDLE;
                end else begin
                    cmd_sr_d = cmd_full[1:0];
                    if (bit_cnt_q == CW'(2)) begin
                        bit_cnt_d = '0;
                        // legal codes are 000, 001, 110, 111
                        if (cmd_full[2] == cmd_full[1]) begin
                            cmd_d   = cmd_full[1:0];
                            state_d = PAYLOAD;
                        end else begin
                            err_pulse_d[E_ILL] = 1'b1;
                            state_d            = WAIT;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            PAYLOAD: begin
                if (SS_n) begin
                    err_pulse_d[E_SHORT] = 1'b1;
                    state_d              = IDLE;
                end else begin
                    pay_sr_d = {pay_sr_q[DATA_WIDTH-2:0], MOSI};
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d  = '0;
                        tail_cnt_d = '0;
                        state_d    = (cmd_q == 2'b11) ? RESP : DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            RESP: begin
                if (SS_n) begin
                    err_pulse_d[E_SHORT] = 1'b1;
                    state_d              = IDLE;
                end else begin
                    resp_sr_d = {resp_sr_q[DATA_WIDTH-2:0], MISO};
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d    = '0;
                        tail_cnt_d   = '0;
                        after_resp_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                if (SS_n) begin
                    state_d         = IDLE;
                    frame_done_d    = 1'b1;
                    frame_cmd_d     = cmd_q;
                    frame_payload_d = pay_sr_q;
                    if (cmd_q == 2'b10) rd_valid_d = 1'b1;
                    if (cmd_q == 2'b11) begin
                        frame_resp_d = resp_sr_q;
                        if (!rd_valid_q) err_pulse_d[E_ORDER] = 1'b1;
                        rd_valid_d = 1'b0;
                    end
                end else begin
                    // counter stops past TAIL_MAX so the flag fires only once
                    if (tail_cnt_q == TW'(TAIL_MAX)) err_pulse_d[E_LONG] = 1'b1;
                    if (tail_cnt_q <= TW'(TAIL_MAX)) tail_cnt_d = tail_cnt_q + TW'(1);
                end
            end
            WAIT: begin
                if (SS_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        err_status_d = (err_clr ? 5'd0 : err_status_q) | err_pulse_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            tail_cnt_q      <= '0;
            cmd_sr_q        <= '0;
            cmd_q           <= '0;
            pay_sr_q        <= '0;
            resp_sr_q       <= '0;
            after_resp_q    <= 1'b0;
            rd_valid_q      <= 1'b0;
            miso_prev_q     <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_cmd_q     <= '0;
            frame_payload_q <= '0;
            frame_resp_q    <= '0;
            err_pulse_q     <= '0;
            err_status_q    <= '0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            tail_cnt_q      <= tail_cnt_d;
            cmd_sr_q        <= cmd_sr_d;
            cmd_q           <= cmd_d;
            pay_sr_q        <= pay_sr_d;
            resp_sr_q       <= resp_sr_d;
            after_resp_q    <= after_resp_d;
            rd_valid_q      <= rd_valid_d;
            miso_prev_q     <= miso_prev_d;
            frame_done_q    <= frame_done_d;
            frame_cmd_q     <= frame_cmd_d;
            frame_payload_q <= frame_payload_d;
            frame_resp_q    <= frame_resp_d;
            err_pulse_q     <= err_pulse_d;
            err_status_q    <= err_status_d;
        end
    end

    assign frame_done    = frame_done_q;
    assign frame_cmd     = frame_cmd_q;
    assign frame_payload = frame_payload_q;
    assign frame_resp    = frame_resp_q;
    assign err_pulse     = err_pulse_q;
    assign err_status    = err_status_q;

`ifdef SPI_MON_CNT_EN
    // indexed by cmd code: 0 wr-addr, 1 wr-data, 2 rd-addr, 3 rd-data
    logic [3:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (frame_done_d && (cnt_q[cmd_q] != {CNT_WIDTH{1'b1}}))
            cnt_d[cmd_q] = cnt_q[cmd_q] + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_wr_addr = cnt_q[0];
    assign cnt_wr_data = cnt_q[1];
    assign cnt_rd_addr = cnt_q[2];
    assign cnt_rd_data = cnt_q[3];
`else
    assign cnt_wr_addr = '0;
    assign cnt_wr_data = '0;
    assign cnt_rd_addr = '0;
    assign cnt_rd_data = '0;
`endif

endmodule

// File: tb/tb_spi_protocol_monitor.sv
// Directed bench for spi_protocol_monitor: a table of whole frames with
// hand-computed results, then hand sequences for short frame / err_clr,
// MISO toggling and reset mid-frame.
module tb_spi_protocol_monitor;

    localparam int DW = 8;
    localparam int CN = 16;

    logic          clk = 1'b0;
    logic          rst, SS_n, MOSI, MISO, err_clr;
    logic          frame_done;
    logic [1:0]    frame_cmd;
    logic [DW-1:0] frame_payload, frame_resp;
    logic [4:0]    err_pulse, err_status;
    logic [CN-1:0] cnt_wr_addr, cnt_wr_data, cnt_rd_addr, cnt_rd_data;

    spi_protocol_monitor #(.DATA_WIDTH(DW), .TAIL_MAX(2), .CNT_WIDTH(CN)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .err_clr(err_clr), .frame_done(frame_done), .frame_cmd(frame_cmd),
        .frame_payload(frame_payload), .frame_resp(frame_resp),
        .err_pulse(err_pulse), .err_status(err_status),
        .cnt_wr_addr(cnt_wr_addr), .cnt_wr_data(cnt_wr_data),
        .cnt_rd_addr(cnt_rd_addr), .cnt_rd_data(cnt_rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // per-frame observation accumulators
    int       done_n;
    int       err_cyc;
    logic [4:0] err_or;

    typedef struct {
        logic [2:0]         cmd;
        logic [7:0]         pay;
        logic [7:0]         resp;
        int                 tail;
        int                 done;
        logic [1:0]         ecmd;
        logic [7:0]         epay;
        logic [7:0]         eresp;
        logic [4:0]         eerr;
        logic [3:0][15:0]   ecnt;   // {rd_data, rd_addr, wr_data, wr_addr}
    } vec_t;

    vec_t vecs [8];

    function automatic logic [15:0] ec(input logic [15:0] v);
`ifdef SPI_MON_CNT_EN
        return v;
`else
        return 16'd0 & v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clr_acc();
        done_n  = 0;
        err_cyc = 0;
        err_or  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_done) done_n++;
        if (err_pulse != 5'd0) err_cyc++;
        err_or |= err_pulse;
    endtask

    // One whole frame; tog >= 0 drives MISO high for that payload bit only.
    task automatic send_frame(input logic [2:0] c, input logic [7:0] p,
                              input logic [7:0] r, input int tail, input int tog);
        clr_acc();
        SS_n = 1'b0; MOSI = 1'b0; MISO = 1'b0;
        tick();                         // IDLE sees SS_n low
        tick();                         // START
        for (int i = 0; i < 3; i++) begin
            MOSI = c[2-i];
            tick();
        end
        for (int i = 0; i < DW; i++) begin
            MOSI = p[DW-1-i];
            MISO = (i == tog);
            tick();
        end
        MISO = 1'b0;
        if (c == 3'b111) begin
            for (int i = 0; i < DW; i++) begin
                MISO = r[DW-1-i];
                tick();
            end
            MISO = 1'b0;
        end
        MOSI = 1'b0;
        repeat (tail) tick();
        SS_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3'b000, 8'hA5, 8'h00, 0, 1, 2'b00, 8'hA5, 8'h00, 5'h00, {16'd0, 16'd0, 16'd0, 16'd1}};
        vecs[1] = '{3'b110, 8'h3C, 8'h00, 1, 1, 2'b10, 8'h3C, 8'h00, 5'h00, {16'd0, 16'd1, 16'd0, 16'd1}};
        vecs[2] = '{3'b111, 8'h00, 8'h96, 1, 1, 2'b11, 8'h00, 8'h96, 5'h00, {16'd1, 16'd1, 16'd0, 16'd1}};
        vecs[3] = '{3'b111, 8'h5A, 8'hC3, 2, 1, 2'b11, 8'h5A, 8'hC3, 5'h10, {16'd2, 16'd1, 16'd0, 16'd1}};
        vecs[4] = '{3'b001, 8'h81, 8'h00, 3, 1, 2'b01, 8'h81, 8'hC3, 5'h04, {16'd2, 16'd1, 16'd1, 16'd1}};
        vecs[5] = '{3'b010, 8'hFF, 8'h00, 0, 0, 2'b01, 8'h81, 8'hC3, 5'h01, {16'd2, 16'd1, 16'd1, 16'd1}};
        vecs[6] = '{3'b100, 8'h55, 8'h00, 1, 0, 2'b01, 8'h81, 8'hC3, 5'h01, {16'd2, 16'd1, 16'd1, 16'd1}};
        vecs[7] = '{3'b001, 8'h00, 8'h00, 2, 1, 2'b01, 8'h00, 8'hC3, 5'h00, {16'd2, 16'd1, 16'd2, 16'd1}};

        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; MISO = 1'b0; err_clr = 1'b0;
        clr_acc();
        tick();
        check("reset_outs", {3'd0, frame_done, frame_cmd, frame_payload, frame_resp,
                             err_pulse, err_status}, 32'd0);
        check("reset_cnts", {cnt_wr_addr | cnt_wr_data, cnt_rd_addr | cnt_rd_data}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            pulse_clr();
            send_frame(vecs[i].cmd, vecs[i].pay, vecs[i].resp, vecs[i].tail, -1);
            check($sformatf("v%0d_done", i), done_n, vecs[i].done);
            check($sformatf("v%0d_err", i), err_or, vecs[i].eerr);
            check($sformatf("v%0d_errcyc", i), err_cyc, (vecs[i].eerr != 5'd0) ? 1 : 0);
            check($sformatf("v%0d_status", i), err_status, vecs[i].eerr);
            check($sformatf("v%0d_cmd", i), frame_cmd, vecs[i].ecmd);
            check($sformatf("v%0d_pay", i), frame_payload, vecs[i].epay);
            check($sformatf("v%0d_resp", i), frame_resp, vecs[i].eresp);
            check($sformatf("v%0d_cnt_wa", i), cnt_wr_addr, ec(vecs[i].ecnt[0]));
            check($sformatf("v%0d_cnt_wd", i), cnt_wr_data, ec(vecs[i].ecnt[1]));
            check($sformatf("v%0d_cnt_ra", i), cnt_rd_addr, ec(vecs[i].ecnt[2]));
            check($sformatf("v%0d_cnt_rd", i), cnt_rd_data, ec(vecs[i].ecnt[3]));
        end

        // illegal cmd then short frame two cycles into PAYLOAD
        pulse_clr();
        send_frame(3'b010, 8'h00, 8'h00, 0, -1);
        check("ill_done", done_n, 0);
        check("ill_err", err_or, 5'h01);
        clr_acc();
        SS_n = 1'b0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            MOSI = (i == 2);
            tick();
        end
        MOSI = 1'b1; tick();
        MOSI = 1'b0; tick();
        SS_n = 1'b1; tick(); tick();
        check("short_done", done_n, 0);
        check("short_err", err_or, 5'h02);
        check("short_status", err_status, 5'h03);
        check("short_pay_hold", frame_payload, 8'h00);
        check("short_cmd_hold", frame_cmd, 2'b01);
        pulse_clr();
        check("clr_status", err_status, 5'h00);

        // MISO toggles during a wr-data payload
        send_frame(3'b001, 8'h3C, 8'h00, 0, 3);
        check("miso_done", done_n, 1);
        check("miso_err", err_or, 5'h08);
        check("miso_pay", frame_payload, 8'h3C);

        // reset in the middle of a payload
        SS_n = 1'b0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin MOSI = 1'b0; tick(); end
        MOSI = 1'b1; tick(); tick(); tick();
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
        tick();
        check("mid_rst_outs", {3'd0, frame_done, frame_cmd, frame_payload, frame_resp,
                               err_pulse, err_status}, 32'd0);
        check("mid_rst_cnts", {cnt_wr_addr | cnt_wr_data, cnt_rd_addr | cnt_rd_data}, 32'd0);
        rst = 1'b0;
        tick();

        send_frame(3'b000, 8'h5A, 8'h00, 1, -1);
        check("post_wa_done", done_n, 1);
        check("post_wa_err", err_or, 5'h00);
        check("post_wa_status", err_status, 5'h00);
        check("post_wa_pay", frame_payload, 8'h5A);
        check("post_wa_cnt", cnt_wr_addr, ec(16'd1));

        send_frame(3'b111, 8'h00, 8'h69, 1, -1);
        check("orphan_rd_done", done_n, 1);
        check("orphan_rd_err", err_or, 5'h10);
        check("orphan_rd_errcyc", err_cyc, 1);
        check("orphan_rd_resp", frame_resp, 8'h69);
        check("orphan_rd_cnt", cnt_rd_data, ec(16'd1));

        send_frame(3'b110, 8'h3C, 8'h00, 0, -1);
        check("ra_err", err_or, 5'h00);
        send_frame(3'b111, 8'h00, 8'h96, 1, -1);
        check("rd_err", err_or, 5'h00);
        check("rd_cmd", frame_cmd, 2'b11);
        check("rd_resp", frame_resp, 8'h96);
        check("rd_cnt", cnt_rd_data, ec(16'd2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
